inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter PC_WIDTH, default `PC_WIDTH from shared defines, PC/address width.
REQ-002 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 work_ena  in  1  core enable; 0 = no pop, no new request.
REQ-006 stall  in  1  decode-side hold; 1 = head entry not consumed this cycle.
REQ-007 redirect  in  1  flush/branch-taken; restart fetch at redirect_pc.
REQ-008 redirect_pc  in  PC_WIDTH  new fetch address; bit[1:0] ignored (forced 0).
REQ-009 imem_req  out  1  instruction-memory request.
REQ-010 imem_addr  out  PC_WIDTH  request address, word aligned.
REQ-011 imem_gnt  in  1  request accepted this cycle (req&gnt = handshake).
REQ-012 imem_rvalid  in  1  response valid, exactly 1 cycle after handshake.
REQ-013 imem_rdata  in  32  response instruction.
REQ-014 if_pc  out  PC_WIDTH  PC of presented instruction.
REQ-015 if_inst  out  32  presented instruction; 0x00000013 (NOP) when if_valid=0.
REQ-016 if_valid  out  1  if_pc/if_inst hold a real fetched instruction.

Function
REQ-017 fetch_pc register holds next request address; +4 per handshake, wraps modulo 2^PC_WIDTH.
REQ-018 2-entry FIFO of {pc, inst}; head drives if_pc/if_inst combinationally when non-empty.
REQ-019 Credit rule: imem_req=1 only when work_ena=1, redirect=0, state=RUN, occupancy+inflight < 2.
REQ-020 imem_req stays asserted with stable imem_addr until imem_gnt (no retraction).
REQ-021 On imem_rvalid with inflight entry not marked discard, push {pc_of_request, imem_rdata}.
REQ-022 Pop head when if_valid=1, stall=0, work_ena=1; push and pop same cycle allowed, occupancy unchanged.
REQ-023 States: RUN (normal), DRAIN (redirect seen while response outstanding).
REQ-024 redirect in RUN: flush FIFO, fetch_pc <= redirect_pc, next request earliest following cycle; if handshake completed previous cycle (response arriving now) -> that response discarded; if handshake this cycle is suppressed (req forced 0).
REQ-025 DRAIN entered only if a request was granted in the redirect cycle; returns to RUN when its rvalid arrives; response dropped.
REQ-026 redirect has priority over stall, work_ena and push; redirect while in DRAIN updates fetch_pc again, stays DRAIN.
REQ-027 work_ena=0: no new requests, no pop; outstanding response still pushed; outputs show NOP with if_valid=0.
REQ-028 Full FIFO never overflows (guaranteed by REQ-019); rvalid when no request outstanding is ignored.
REQ-029 Best case throughput 1 instruction/cycle; first if_valid 2 cycles after first grant-free reset release (gnt=1).

Reset
REQ-030 rst: fetch_pc=RESET_PC, FIFO empty, inflight=0, state=RUN, imem_req=0, if_valid=0, if_pc=0, if_inst=0x00000013.
REQ-031 rst mid-transaction discards any outstanding response arriving after reset.

Structure
REQ-032 NOP encoding 0x00000013 and PC_WIDTH belong in shared defines.vh, not local literals.
REQ-033 One sub-module natural: fetch_fifo (2-entry, push/pop/flush, full/empty).

Verification
REQ-034 Reset release, gnt=1 always, stall=0 -> addresses 0,4,8,... each cycle; if_pc follows 1 cycle behind response, if_valid continuous.
REQ-035 stall=1 for 3 cycles with gnt=1 -> FIFO fills to 2, imem_req drops, if_pc frozen; release -> sequential order, no loss/duplication.
REQ-036 redirect to 0x100 while response for 0x20 in flight -> 0x20 never presented; next if_pc=0x100, then 0x104.
REQ-037 gnt=0 for 4 cycles at addr 0x40 -> imem_addr held 0x40, req held; fetch resumes 0x44 after grant.
REQ-038 redirect and stall same cycle with full FIFO -> FIFO flushed, if_valid=0, if_inst=0x00000013 next cycle.
REQ-039 rst asserted with request in flight -> next cycle outputs reset values; stale rvalid not pushed; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned IF_PC_WIDTH = 32;
    localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        IF_RUN   = 1'b0,
        IF_DRAIN = 1'b1
    } if_state_e;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry {pc, inst} queue between the memory response and decode.
module inst_fetch_fifo #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic [1:0]    count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic          do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) wr_ptr_d = ~wr_ptr_q;
            if (do_pop) rd_ptr_d = ~rd_ptr_q;
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; the count alone says what is live.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited single-outstanding requests into a
// 2-entry queue, with redirect flushing and a drain state for late responses.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned         PC_WIDTH = IF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                work_ena,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_inst,
    output logic                if_valid,
    output if_state_e           dbg_state_o
);

    localparam int unsigned EW = PC_WIDTH + 32;

    if_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;

    logic                handshake;
    logic                rsp_arrive;
    logic                push;
    logic                pop;
    logic [2:0]          credit_used;
    logic                fifo_empty;
    logic                fifo_full;
    logic [1:0]          fifo_count;
    logic [EW-1:0]       head;
    logic [PC_WIDTH-1:0] redirect_pc_aligned;
    logic                unused_pc_bits;

    assign redirect_pc_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_pc_bits      = ^redirect_pc[1:0];

    assign handshake   = imem_req & imem_gnt;
    assign rsp_arrive  = imem_rvalid & inflight_q;
    assign imem_addr   = fetch_pc_q;
    assign dbg_state_o = state_q;

    assign if_valid = work_ena & ~fifo_empty;
    assign if_pc    = if_valid ? head[EW-1:32] : '0;
    assign if_inst  = if_valid ? head[31:0] : IF_NOP_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IF_RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;

        if (handshake) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end else if (rsp_arrive) begin
            inflight_d = 1'b0;
        end

        if (redirect) fetch_pc_d = redirect_pc_aligned;
        else if (handshake) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);

        // A redirect only needs to drain when its stale response has not
        // already landed in the redirect cycle itself.
        case (state_q)
            IF_RUN:   if (redirect && inflight_q && !imem_rvalid) state_d = IF_DRAIN;
            IF_DRAIN: if (rsp_arrive) state_d = IF_RUN;
            default:  state_d = IF_RUN;
        endcase
    end

    always_comb begin
        pop  = if_valid & ~stall & ~redirect;
        push = rsp_arrive & (state_q == IF_RUN) & ~redirect & (~fifo_full | pop);
        // Entries after this cycle's pop plus any response landing now must
        // leave a slot free before another request goes out.
        credit_used = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, inflight_q};
        imem_req    = work_ena & ~redirect & (state_q == IF_RUN)
                    & (~inflight_q | imem_rvalid) & (credit_used < 3'd2);
    end

    inst_fetch_fifo #(
        .DW(EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle memory responder and a
// scoreboard of expected fetch PCs.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int unsigned    PW          = 32;
    localparam logic [PW-1:0]  TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0]    TB_NOP      = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          work_ena;
    logic          stall;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic [PW-1:0] if_pc;
    logic [31:0]   if_inst;
    logic          if_valid;
    if_state_e     dbg_state;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] model_pc;
    logic          pend;
    logic [PW-1:0] pend_addr;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .PC_WIDTH(PW),
        .RESET_PC(TB_RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .work_ena    (work_ena),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_valid    (if_valid),
        .dbg_state_o (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [PW-1:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic head_check(input string name);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, if_pc 0x%0h", name, if_pc);
        end else begin
            check(name, if_pc, exp_q[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Memory: answers every handshake one cycle later; expected PCs are
    // queued from the bench's own address model.
    initial begin : responder
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        model_pc    = TB_RESET_PC;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_pc = TB_RESET_PC;
            end else if (redirect) begin
                exp_q.delete();
                model_pc = {redirect_pc[PW-1:2], 2'b00};
                check("req_in_redirect", 32'(imem_req), 32'd0);
            end else if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, model_pc);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
            pend      = imem_req && imem_gnt;
            pend_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = pend;
            imem_rdata  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        end
    end

    initial begin : monitor
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !redirect && work_ena && !stall && if_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: if_pc 0x%0h if_inst 0x%0h with nothing expected", if_pc, if_inst);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e);
                    check("if_inst", if_inst, mem_word(e));
                end
            end
        end
    end

    initial begin : stimulus
        rst         = 1'b1;
        work_ena    = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        tick();
        tick();
        sample();
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, TB_NOP);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        check("rst_state", 32'(dbg_state), 32'(IF_RUN));

        // Streaming from reset: one request per cycle, first instruction two cycles in.
        tick(); rst = 1'b0; work_ena = 1'b1; imem_gnt = 1'b1;
        sample();
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        check("c0_valid", 32'(if_valid), 32'd0);
        tick(); sample();
        check("c1_addr", imem_addr, 32'h4);
        check("c1_valid", 32'(if_valid), 32'd0);
        tick(); sample();
        check("c2_valid", 32'(if_valid), 32'd1);
        check("c2_pc", if_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(); sample();
            check("stream_valid", 32'(if_valid), 32'd1);
        end

        // Stall for three cycles: queue fills, requests stop, head frozen.
        tick(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            sample();
            check("stall_req", 32'(imem_req), 32'd0);
            check("stall_valid", 32'(if_valid), 32'd1);
            head_check("stall_head");
        end
        tick(); stall = 1'b0;
        sample();
        check("unstall_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin tick(); sample(); end

        // Redirect to 0x43 (forced to 0x40), then hold off the grant.
        tick(); redirect = 1'b1; redirect_pc = 32'h43; imem_gnt = 1'b0;
        sample();
        tick(); redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            sample();
            check("nogrant_req", 32'(imem_req), 32'd1);
            check("nogrant_addr", imem_addr, 32'h40);
            check("nogrant_valid", 32'(if_valid), 32'd0);
        end
        tick(); imem_gnt = 1'b1;
        sample();
        check("grant_addr", imem_addr, 32'h40);
        tick(); sample();
        check("after_grant_addr", imem_addr, 32'h44);
        for (int i = 0; i < 4; i++) begin tick(); sample(); end

        // Redirect to 0x100 while the response for 0x20 is in flight.
        tick(); redirect = 1'b1; redirect_pc = 32'h18;
        sample();
        tick(); redirect = 1'b0;
        sample();
        check("d_addr_18", imem_addr, 32'h18);
        tick(); sample();
        check("d_addr_1c", imem_addr, 32'h1C);
        tick(); sample();
        check("d_addr_20", imem_addr, 32'h20);
        check("d_req_20", 32'(imem_req), 32'd1);
        tick(); redirect = 1'b1; redirect_pc = 32'h100;
        sample();
        tick(); redirect = 1'b0;
        sample();
        check("d_addr_100", imem_addr, 32'h100);
        check("d_valid_c4", 32'(if_valid), 32'd0);
        tick(); sample();
        check("d_valid_c5", 32'(if_valid), 32'd0);
        tick(); sample();
        check("d_valid_c6", 32'(if_valid), 32'd1);
        check("d_pc_100", if_pc, 32'h100);
        tick(); sample();
        check("d_pc_104", if_pc, 32'h104);
        for (int i = 0; i < 3; i++) begin tick(); sample(); end

        // Redirect together with stall on a full queue.
        tick(); stall = 1'b1;
        sample();
        tick(); sample();
        tick(); sample();
        check("full_req", 32'(imem_req), 32'd0);
        tick(); redirect = 1'b1; redirect_pc = 32'h200;
        sample();
        tick(); redirect = 1'b0; stall = 1'b0;
        sample();
        check("flush_valid", 32'(if_valid), 32'd0);
        check("flush_inst", if_inst, TB_NOP);
        check("flush_pc", if_pc, 32'h0);
        check("flush_addr", imem_addr, 32'h200);
        check("flush_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 5; i++) begin tick(); sample(); end

        // Core disabled for three cycles: NOP out, no requests, nothing lost.
        tick(); work_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            sample();
            check("dis_req", 32'(imem_req), 32'd0);
            check("dis_valid", 32'(if_valid), 32'd0);
            check("dis_inst", if_inst, TB_NOP);
        end
        tick(); work_ena = 1'b1;
        sample();
        check("en_valid", 32'(if_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin tick(); sample(); end

        // Reset with a request in flight; its late response must be ignored.
        tick(); rst = 1'b1;
        sample();
        tick(); rst = 1'b0;
        sample();
        check("mid_rst_valid", 32'(if_valid), 32'd0);
        check("mid_rst_pc", if_pc, 32'h0);
        check("mid_rst_inst", if_inst, TB_NOP);
        check("mid_rst_addr", imem_addr, TB_RESET_PC);
        check("mid_rst_state", 32'(dbg_state), 32'(IF_RUN));
        tick(); sample();
        check("stale_not_pushed", 32'(if_valid), 32'd0);
        tick(); sample();
        check("restart_valid", 32'(if_valid), 32'd1);
        check("restart_pc", if_pc, TB_RESET_PC);
        for (int i = 0; i < 4; i++) begin tick(); sample(); end

        // Stop granting and let everything drain.
        tick(); imem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        sample();
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(if_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
